// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Iterative radix-2 HI/LO multiply/divide unit (MULT/MULTU/DIV/
//               DIVU/MTHI/MTLO). Divider present only when MULDIV_DIV_EN is
//               defined.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             rd_req,
    input  logic             rd_sel,
    output logic [WIDTH-1:0] rd_data,
    output logic             busy,
    output logic             done,
    output logic             stall,
    output logic             dz
);

    localparam int                 c_CNT_W = $clog2(WIDTH + 1);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]         r_state;
    logic [0:0]         w_stateNext;
    logic [c_CNT_W-1:0] r_count;
    logic [2*WIDTH:0]   r_acc;
    logic [WIDTH-1:0]   r_opnd;
    logic               r_negQ;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;
    logic               r_dz;

    logic               w_isMul;
    logic               w_signed;
    logic               w_aNeg;
    logic               w_bNeg;
    logic [WIDTH-1:0]   w_magA;
    logic [WIDTH-1:0]   w_magB;
    logic               w_accept;
    logic               w_launch;
    logic               w_last;
    logic [WIDTH:0]     w_mulSum;
    logic [2*WIDTH:0]   w_mulAcc;
    logic [2*WIDTH:0]   w_stepAcc;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_resHi;
    logic [WIDTH-1:0]   w_resLo;

`ifdef MULDIV_DIV_EN
    logic               r_isDiv;
    logic               r_negR;
    logic               w_isDiv;
    logic               w_bZero;
    logic [WIDTH:0]     w_shifted;
    logic [WIDTH:0]     w_diff;
    logic [2*WIDTH:0]   w_divAcc;
`endif

    // Operand decode; signed ops work on magnitudes and fix the sign at the end
    always_comb begin
        w_isMul  = (op[2:1] == 2'b00);
        w_signed = ~op[0];
        w_aNeg   = w_signed & a[WIDTH-1];
        w_bNeg   = w_signed & b[WIDTH-1];
        w_magA   = w_aNeg ? -a : a;
        w_magB   = w_bNeg ? -b : b;
        w_accept = start & (r_state == S_IDLE);
`ifdef MULDIV_DIV_EN
        w_isDiv  = (op[2:1] == 2'b01);
        w_bZero  = (b == '0);
        w_launch = w_accept & (w_isMul | (w_isDiv & ~w_bZero));
`else
        w_launch = w_accept & w_isMul;
`endif
        w_last   = (r_state == S_RUN) & (r_count == c_LAST);
    end

    // One radix-2 step: shift-add multiply or restoring divide
    always_comb begin
        w_mulSum  = r_acc[2*WIDTH:WIDTH] + (r_acc[0] ? {1'b0, r_opnd} : '0);
        w_mulAcc  = {1'b0, w_mulSum, r_acc[WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
        w_shifted = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
        w_diff    = w_shifted - {1'b0, r_opnd};
        w_divAcc  = w_diff[WIDTH] ? {w_shifted, r_acc[WIDTH-2:0], 1'b0}
                                  : {w_diff,    r_acc[WIDTH-2:0], 1'b1};
        w_stepAcc = r_isDiv ? w_divAcc : w_mulAcc;
`else
        w_stepAcc = w_mulAcc;
`endif
        w_prod    = r_negQ ? -w_stepAcc[2*WIDTH-1:0] : w_stepAcc[2*WIDTH-1:0];
        w_resHi   = w_prod[2*WIDTH-1:WIDTH];
        w_resLo   = w_prod[WIDTH-1:0];
`ifdef MULDIV_DIV_EN
        if (r_isDiv) begin
            w_resLo = r_negQ ? -w_stepAcc[WIDTH-1:0] : w_stepAcc[WIDTH-1:0];
            w_resHi = r_negR ? -w_stepAcc[2*WIDTH-1:WIDTH] : w_stepAcc[2*WIDTH-1:WIDTH];
        end
`endif
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            S_IDLE:  if (w_launch) w_stateNext = S_RUN;
            S_RUN:   if (w_last)   w_stateNext = S_IDLE;
            default: w_stateNext = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_count <= '0;
            r_acc   <= '0;
            r_opnd  <= '0;
            r_negQ  <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_done  <= 1'b0;
            r_dz    <= 1'b0;
`ifdef MULDIV_DIV_EN
            r_isDiv <= 1'b0;
            r_negR  <= 1'b0;
`endif
        end else begin
            r_state <= w_stateNext;
            r_done  <= 1'b0;
            r_dz    <= 1'b0;
            if (w_launch) begin
                r_count <= '0;
                r_negQ  <= w_aNeg ^ w_bNeg;
                r_acc   <= {{(WIDTH+1){1'b0}}, w_magB};
                r_opnd  <= w_magA;
`ifdef MULDIV_DIV_EN
                r_isDiv <= w_isDiv;
                r_negR  <= w_aNeg;
                if (w_isDiv) begin
                    r_acc  <= {{(WIDTH+1){1'b0}}, w_magA};
                    r_opnd <= w_magB;
                end
`endif
            end else if (r_state == S_RUN) begin
                r_acc   <= w_stepAcc;
                r_count <= r_count + c_ONE;
                if (w_last) begin
                    r_hi   <= w_resHi;
                    r_lo   <= w_resLo;
                    r_done <= 1'b1;
                end
            end else if (w_accept) begin
                case (op)
                    3'b100: r_hi <= a;
                    3'b101: r_lo <= a;
                    // Divides that did not launch complete in a single cycle
                    3'b010, 3'b011: begin
`ifdef MULDIV_DIV_EN
                        r_hi <= a;
                        r_lo <= '1;
                        r_dz <= 1'b1;
`endif
                        r_done <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign busy    = (r_state == S_RUN);
    assign stall   = busy & (rd_req | start);
    assign rd_data = rd_sel ? r_hi : r_lo;
    assign done    = r_done;
    assign dz      = r_dz;

endmodule
`default_nettype wire

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter WIDTH, default 32, operand/HI/LO width; legal range 4..64.
REQ-002 clk  input  1  rising-edge clock, sole clock of block.
REQ-003 Reset  input  1  synchronous, active-low reset (asserted when 0, sampled on clk rising edge).
REQ-004 start  input  1  request to launch op in current cycle.
REQ-005 op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x no-op.
REQ-006 a  input  WIDTH  operand A (multiplicand/dividend/MTHI-MTLO source).
REQ-007 b  input  WIDTH  operand B (multiplier/divisor).
REQ-008 rd_req  input  1  ID-stage MFHI/MFLO present.
REQ-009 rd_sel  input  1  0 selects LO, 1 selects HI.
REQ-010 rd_data  output  WIDTH  selected HI/LO register contents.
REQ-011 busy  output  1  iterative op in progress.
REQ-012 done  output  1  one-cycle pulse: HI/LO hold new result.
REQ-013 stall  output  1  pipeline hold request to hazard logic.
REQ-014 dz  output  1  one-cycle pulse with done on divide by zero.

Function
REQ-015 States IDLE, RUN; transitions IDLE->RUN on accepted MULT/MULTU/DIV/DIVU (b!=0 for divides), RUN->IDLE after WIDTH iterations.
REQ-016 start accepted only in IDLE; start in RUN ignored, no state change.
REQ-017 Accept at edge k: busy=1 in cycles k+1..k+WIDTH; HI/LO written and done=1 in cycle k+WIDTH+1.
REQ-018 One radix-2 iteration per RUN cycle; iteration counter clog2(WIDTH+1) bits, no wrap.
REQ-019 MULT/MULTU: {HI,LO} = full 2*WIDTH product; MULT signed two's complement, MULTU unsigned.
REQ-020 Signed ops computed on magnitudes, sign applied on final write.
REQ-021 DIV/DIVU: LO = quotient, HI = remainder; signed quotient truncates toward zero, remainder takes dividend sign.
REQ-022 DIV of most-negative by -1: LO = most-negative value, HI = 0, normal latency.
REQ-023 Divide with b==0: no RUN; at edge k+1 HI=a, LO=all ones; done=1 and dz=1 in cycle k+1; busy never set.
REQ-024 MTHI/MTLO accepted in IDLE: HI or LO = a at edge k; no busy, no done.
REQ-025 rd_data combinational from HI/LO registers; during RUN returns pre-op values.
REQ-026 stall = busy & (rd_req | start), combinational.
REQ-027 Accept in same cycle as done pulse permitted; new result does not disturb done already presented.

Reset
REQ-028 Reset low at edge: state IDLE, HI=0, LO=0, counter=0, busy=0, done=0, dz=0; in-flight op discarded, no partial HI/LO write.
REQ-029 Reset priority over start in same cycle.

Configuration
REQ-030 Macro MULDIV_DIV_EN defined: divider datapath and REQ-021..REQ-023 present.
REQ-031 MULDIV_DIV_EN undefined: divider logic absent; DIV/DIVU accepted as single-cycle no-op, HI/LO unchanged, done=1 and dz=0 in cycle k+1, busy never set.

Verification
REQ-032 WIDTH=32, MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> done at cycle k+33, HI=0xFFFFFFFE, LO=0x00000001.
REQ-033 MULT a=-3 b=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; busy high exactly 32 cycles.
REQ-034 DIV a=-7 b=2 (MULDIV_DIV_EN defined) -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIV a=5 b=0 -> cycle k+1 done=1, dz=1, HI=5, LO=0xFFFFFFFF.
REQ-035 rd_req=1 during RUN -> stall=1 every busy cycle, rd_data=old HI/LO; second start mid-RUN ignored, stall=1.
REQ-036 Reset low at iteration 10 of MULT after MTHI a=0x1234 -> next cycle busy=0, HI=0, LO=0, no done pulse.
